// File: rtl/ccc_clken_pkg.sv
// rtl/ccc_clken_pkg.sv - shared types and helpers for the CCC clock-enable generator
package ccc_clken_pkg;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_FILT = 2'd1,
    ST_HOLD = 2'd2,
    ST_RUN  = 2'd3
  } state_e;

  localparam int LOSS_CNT_W = 8;

  // Counter that sticks at all-ones instead of wrapping.
  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + LOSS_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mss_ccc_clken_gen_if.sv
// rtl/mss_ccc_clken_gen_if.sv - divide-programming and clock-enable bus of the generator
interface mss_ccc_clken_gen_if #(
  parameter int NCH  = 3,
  parameter int DIVW = 8
);
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;

  logic                                div_we;
  logic [SELW-1:0]                     div_sel;
  logic [DIVW-1:0]                     div_val;
  logic                                realign;
  logic                                locked;
  logic                                rst_out;
  logic [NCH-1:0]                      clken;
  logic [ccc_clken_pkg::LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    output div_we, div_sel, div_val, realign,
    input  locked, rst_out, clken, lock_loss_cnt
  );

  modport slave (
    input  div_we, div_sel, div_val, realign,
    output locked, rst_out, clken, lock_loss_cnt
  );

endinterface

// File: rtl/ccc_sync.sv
// rtl/ccc_sync.sv - multi-flop synchroniser for a single asynchronous level
module ccc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mss_ccc_clken_gen.sv
// rtl/mss_ccc_clken_gen.sv - lock qualification, reset sequencing and phase-aligned clock enables
module mss_ccc_clken_gen import ccc_clken_pkg::*; #(
  parameter int NCH         = 3,
  parameter int DIVW        = 8,
  parameter int LOCK_FILT   = 16,
  parameter int RST_HOLD    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DIV_RST     = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lock_in,
  mss_ccc_clken_gen_if.slave   bus
);

  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int FW   = $clog2(LOCK_FILT + 1);
  localparam int HW   = $clog2(RST_HOLD + 1);

  logic                  lock_s;
  state_e                state_q, state_d;
  logic [FW-1:0]         filt_q, filt_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  locked_q, rst_out_q;
  logic                  run_q, run_d, run_entry;
  logic [NCH-1:0]        clken_w;

  ccc_sync #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d_i (lock_in),
    .q_o (lock_s)
  );

  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    hold_d  = hold_q;
    loss_d  = loss_q;
    case (state_q)
      ST_WAIT: begin
        if (lock_s) begin
          state_d = ST_FILT;
          filt_d  = FW'(1);
        end
      end
      ST_FILT: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          filt_d  = '0;
        end else if (filt_q == FW'(LOCK_FILT)) begin
          state_d = ST_HOLD;
          hold_d  = HW'(1);
        end else begin
          filt_d  = filt_q + FW'(1);
        end
      end
      ST_HOLD: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
        end else if (hold_q == HW'(RST_HOLD)) begin
          state_d = ST_RUN;
        end else begin
          hold_d  = hold_q + HW'(1);
        end
      end
      ST_RUN: begin
        if (!lock_s) begin
          state_d = ST_WAIT;
          loss_d  = sat_inc(loss_q);
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  assign run_q     = (state_q == ST_RUN);
  assign run_d     = (state_d == ST_RUN);
  assign run_entry = run_d && !run_q;

  // locked/rst_out come from next-state so they change on the same edge as the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_WAIT;
      filt_q    <= '0;
      hold_q    <= '0;
      loss_q    <= '0;
      locked_q  <= 1'b0;
      rst_out_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      filt_q    <= filt_d;
      hold_q    <= hold_d;
      loss_q    <= loss_d;
      locked_q  <= run_d;
      rst_out_q <= !run_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DIVW-1:0] shadow_q, shadow_d;
    logic [DIVW-1:0] act_q, act_d;
    logic [DIVW-1:0] cnt_q, cnt_d;
    logic            clken_q;

    // Active ratio reloads only at a period boundary, so no runt or stretched period.
    always_comb begin
      shadow_d = shadow_q;
      act_d    = act_q;
      cnt_d    = '0;
      if (bus.div_we && (bus.div_sel == SELW'(i))) begin
        shadow_d = bus.div_val;
      end
      if (run_d) begin
        if (run_entry || bus.realign || (cnt_q == act_q)) begin
          cnt_d = '0;
          act_d = shadow_d;
        end else begin
          cnt_d = cnt_q + DIVW'(1);
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        shadow_q <= DIVW'(DIV_RST);
        act_q    <= DIVW'(DIV_RST);
        cnt_q    <= '0;
        clken_q  <= 1'b0;
      end else begin
        shadow_q <= shadow_d;
        act_q    <= act_d;
        cnt_q    <= cnt_d;
        clken_q  <= run_d && (cnt_d == '0);
      end
    end

    assign clken_w[i] = clken_q;
  end

  assign bus.locked        = locked_q;
  assign bus.rst_out       = rst_out_q;
  assign bus.clken         = clken_w;
  assign bus.lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_mss_ccc_clken_gen.sv
// tb/tb_mss_ccc_clken_gen.sv - directed scoreboard bench for mss_ccc_clken_gen
module tb_mss_ccc_clken_gen;

  logic clk     = 1'b0;
  logic reset   = 1'b1;
  logic lock_in = 1'b0;
  int   n_chk   = 0;
  int   n_pass  = 0;
  logic [2:0] exp_q[$];

  mss_ccc_clken_gen_if #(.NCH(3), .DIVW(8)) bus ();

  mss_ccc_clken_gen #(
    .NCH(3), .DIVW(8), .LOCK_FILT(16), .RST_HOLD(8), .SYNC_STAGES(2), .DIV_RST(0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .lock_in (lock_in),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // First entry is compared in the current cycle, the rest one per following cycle.
  task automatic drain(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) step();
      check(tag, 32'(bus.clken), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic wait_locked(input int budget);
    int k;
    k = 0;
    while (!bus.locked && k < budget) begin
      step();
      k++;
    end
    check("relock_in_budget", 32'(bus.locked), 32'd1);
  endtask

  task automatic drop_lock();
    lock_in = 1'b0;
    step();
    lock_in = 1'b1;
    step();
    step();
  endtask

  initial begin
    bus.div_we  = 1'b0;
    bus.div_sel = '0;
    bus.div_val = '0;
    bus.realign = 1'b0;

    // Reset values, lock already high
    lock_in = 1'b1;
    step();
    step();
    check("rst_locked", 32'(bus.locked), 32'd0);
    check("rst_rst_out", 32'(bus.rst_out), 32'd1);
    check("rst_clken", 32'(bus.clken), 32'd0);
    check("rst_loss", 32'(bus.lock_loss_cnt), 32'd0);

    // Qualification with divide values written before lock; sel=3 must be ignored
    reset = 1'b0;
    for (int e = 1; e <= 26; e++) begin
      step();
      case (e)
        1: begin bus.div_we = 1'b1; bus.div_sel = 2'd0; bus.div_val = 8'd0; end
        2: begin bus.div_sel = 2'd1; bus.div_val = 8'd2; end
        3: begin bus.div_sel = 2'd2; bus.div_val = 8'd4; end
        4: begin bus.div_sel = 2'd3; bus.div_val = 8'd7; end
        5: bus.div_we = 1'b0;
        default: ;
      endcase
    end
    check("qual26_locked", 32'(bus.locked), 32'd0);
    check("qual26_rst_out", 32'(bus.rst_out), 32'd1);
    step();
    check("qual27_locked", 32'(bus.locked), 32'd1);
    check("qual27_rst_out", 32'(bus.rst_out), 32'd0);
    check("qual27_loss", 32'(bus.lock_loss_cnt), 32'd0);
    for (int t = 0; t <= 15; t++) exp_q.push_back({t % 5 == 0, t % 3 == 0, 1'b1});
    drain("div_pattern");

    // ch1 rewritten 2 -> 6 mid-period: current period completes, then period 7
    step();
    bus.div_we = 1'b1; bus.div_sel = 2'd1; bus.div_val = 8'd6;
    step();
    bus.div_we = 1'b0;
    for (int t = 17; t <= 32; t++)
      exp_q.push_back({t % 5 == 0, (t == 18 || t == 25 || t == 32), 1'b1});
    drain("div_update");

    // Realign while out of phase
    step();
    bus.realign = 1'b1;
    step();
    bus.realign = 1'b0;
    for (int k = 0; k <= 7; k++) exp_q.push_back({k % 5 == 0, k % 7 == 0, 1'b1});
    drain("realign");

    // One-cycle lock drop in RUN
    lock_in = 1'b0;
    step();
    lock_in = 1'b1;
    step();
    check("drop_sync_delay_locked", 32'(bus.locked), 32'd1);
    step();
    check("drop_rst_out", 32'(bus.rst_out), 32'd1);
    check("drop_locked", 32'(bus.locked), 32'd0);
    check("drop_clken", 32'(bus.clken), 32'd0);
    check("drop_loss", 32'(bus.lock_loss_cnt), 32'd1);
    wait_locked(40);

    // Saturation of the loss counter
    for (int d = 2; d <= 300; d++) begin
      drop_lock();
      if (d == 254) check("loss_254", 32'(bus.lock_loss_cnt), 32'd254);
      if (d == 255) check("loss_255", 32'(bus.lock_loss_cnt), 32'd255);
      wait_locked(40);
    end
    check("loss_saturated", 32'(bus.lock_loss_cnt), 32'd255);

    // Asynchronous reset mid-RUN, then shadows must be back at DIV_RST
    #3 reset = 1'b1;
    #1;
    check("async_rst_locked", 32'(bus.locked), 32'd0);
    check("async_rst_rst_out", 32'(bus.rst_out), 32'd1);
    check("async_rst_clken", 32'(bus.clken), 32'd0);
    check("async_rst_loss", 32'(bus.lock_loss_cnt), 32'd0);
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 26; e++) step();
    check("requal26_locked", 32'(bus.locked), 32'd0);
    step();
    check("requal27_locked", 32'(bus.locked), 32'd1);
    for (int k = 0; k < 3; k++) exp_q.push_back(3'b111);
    drain("post_reset_div");

    // Lock drop during filtering restarts the full qualification
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    for (int e = 1; e <= 10; e++) step();
    lock_in = 1'b0;
    for (int e = 11; e <= 13; e++) step();
    lock_in = 1'b1;
    for (int e = 14; e <= 39; e++) step();
    check("filt_drop_e39_locked", 32'(bus.locked), 32'd0);
    check("filt_drop_e39_rst_out", 32'(bus.rst_out), 32'd1);
    step();
    check("filt_drop_e40_locked", 32'(bus.locked), 32'd1);
    check("filt_drop_loss", 32'(bus.lock_loss_cnt), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
